// File: rtl/uart_rx_fifo.sv
// UART receiver with mid-bit sampling, framing/overflow detection and a FWFT receive FIFO.
// Optional parity checking is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 9,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                            clk_27mhz,
    input  logic                            rst,
    input  logic                            i_rx,
    input  logic                            i_rd_en,
    output logic [DATA_BITS-1:0]            o_rd_data,
    output logic                            o_empty,
    output logic                            o_full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] o_count,
    output logic                            o_rx_bsy,
    output logic                            o_frame_err,
    output logic                            o_parity_err,
    output logic                            o_overflow
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 4) begin : g_bad_cpb
        $error("CLKS_PER_BIT must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_db
        $error("DATA_BITS must be 5..8");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_par
        $error("PARITY must be 0, 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4,
        S_BREAK = 3'd5
    } state_t;
`endif

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic                 r_rx_d;
    logic [CW-1:0]        r_clk_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 w_half_tick;
    logic                 w_bit_tick;
    logic                 w_cnt_clr;
    logic                 w_shift;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_frame_err;
    logic                 w_overflow;
`ifdef UART_RX_PARITY_EN
    logic                 w_par_sample;
    logic                 w_parity_err;
    logic                 r_par_bad;
`endif

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [NW-1:0]        r_count;

    // Synchroniser and edge history all idle high so reset never fakes a start edge.
    always_ff @(posedge clk_27mhz) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_d    <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_s    <= r_rx_meta;
            r_rx_d    <= r_rx_s;
        end
    end

    always_ff @(posedge clk_27mhz) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_half_tick = (r_clk_cnt == HALF_M1);
    assign w_bit_tick  = (r_clk_cnt == FULL_M1);

    always_comb begin
        w_state_next = r_state;
        w_cnt_clr    = 1'b0;
        w_shift      = 1'b0;
        w_push       = 1'b0;
        w_frame_err  = 1'b0;
        w_overflow   = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_sample = 1'b0;
        w_parity_err = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (r_rx_d && !r_rx_s) begin
                    w_state_next = S_START;
                    w_cnt_clr    = 1'b1;
                end
            end
            S_START: begin
                if (w_half_tick) begin
                    w_cnt_clr    = 1'b1;
                    w_state_next = r_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_tick) begin
                    w_cnt_clr = 1'b1;
                    w_shift   = 1'b1;
                    if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
`else
                        w_state_next = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_bit_tick) begin
                    w_cnt_clr    = 1'b1;
                    w_par_sample = 1'b1;
                    w_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_tick) begin
                    w_cnt_clr = 1'b1;
                    if (!r_rx_s) begin
                        w_frame_err  = 1'b1;
                        w_state_next = S_BREAK;
                    end else begin
                        w_state_next = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (r_par_bad) w_parity_err = 1'b1;
                        else
`endif
                        if (o_full && !i_rd_en) w_overflow = 1'b1;
                        else w_push = 1'b1;
                    end
                end
            end
            S_BREAK: begin
                if (r_rx_s) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_27mhz) begin
        if (rst) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            if (w_cnt_clr) r_clk_cnt <= '0;
            else if (r_state != S_IDLE && r_state != S_BREAK) r_clk_cnt <= r_clk_cnt + 1'b1;
            if (r_state == S_START) r_bit_cnt <= '0;
            else if (w_shift) r_bit_cnt <= r_bit_cnt + 1'b1;
            if (w_shift) r_shift[r_bit_cnt] <= r_rx_s;
        end
    end

`ifdef UART_RX_PARITY_EN
    // XOR over data plus parity bit is 1 for a good odd frame and 0 for a good even frame.
    always_ff @(posedge clk_27mhz) begin
        if (rst) begin
            r_par_bad    <= 1'b0;
            o_parity_err <= 1'b0;
        end else begin
            o_parity_err <= w_parity_err;
            if (r_state == S_START) r_par_bad <= 1'b0;
            else if (w_par_sample) r_par_bad <= ((^r_shift) ^ r_rx_s) != (PARITY == 1);
        end
    end
`else
    assign o_parity_err = 1'b0;
`endif

    always_ff @(posedge clk_27mhz) begin
        if (rst) begin
            o_frame_err <= 1'b0;
            o_overflow  <= 1'b0;
        end else begin
            o_frame_err <= w_frame_err;
            o_overflow  <= w_overflow;
        end
    end

    assign w_pop = i_rd_en && !o_empty;

    always_ff @(posedge clk_27mhz) begin
        if (w_push) r_mem[r_wr_ptr] <= r_shift;
    end

    always_ff @(posedge clk_27mhz) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count   = r_count;
    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == NW'(FIFO_DEPTH));
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_rx_bsy  = (r_state != S_IDLE);

endmodule
